// File: rtl/flit_router_port.sv
// Wormhole router input port: buffers the NI flit stream and steers each packet to one of four channels.
// Optional STRIP_HEADER_EN drops the header flit at decode instead of forwarding it.
module flit_router_port #(
    parameter int          DEPTH   = 4,
    parameter logic [5:0]  HDR_TAG = 6'b101111,
    parameter logic [7:0]  TRAILER = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_flit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_flit,
    output logic [3:0] out_valid,
    input  logic [3:0] out_ready,
    output logic       pkt_active,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, FWD} state_t;

    state_t      state;
    logic [1:0]  dest;
    logic [2:0]  flit_cnt;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic       empty;
    logic       full;
    logic [7:0] head;
    logic       hdr_ok;
    logic       fwd_valid;
    logic       hs;
    logic       drop;
    logic       strip;
    logic       pop;
    logic       push;
    logic       close;

`ifdef STRIP_HEADER_EN
    localparam logic [2:0] CNT_START = 3'd1;
    assign strip = (state == IDLE) && !empty && hdr_ok;
`else
    localparam logic [2:0] CNT_START = 3'd0;
    assign strip = 1'b0;
`endif

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign hdr_ok    = (head[7:2] == HDR_TAG);
    assign fwd_valid = (state == FWD) && !empty;
    assign hs        = fwd_valid && out_ready[dest];
    assign drop      = (state == IDLE) && !empty && !hdr_ok;
    assign pop       = hs || drop || strip;
    assign push      = in_valid && !full;
    // Closing flit: a trailer after the first flit, or the sixth flit of the packet regardless of value.
    assign close     = hs && (((flit_cnt != 3'd0) && (head == TRAILER)) || (flit_cnt == 3'd5));

    assign in_ready   = !full;
    assign out_flit   = fwd_valid ? head : 8'h00;
    assign out_valid  = fwd_valid ? (4'b0001 << dest) : 4'b0000;
    assign pkt_active = (state == FWD);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dest       <= 2'd0;
            flit_cnt   <= 3'd0;
            drop_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (hdr_ok) begin
                            dest     <= head[1:0];
                            flit_cnt <= CNT_START;
                            state    <= FWD;
                        end else if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                FWD: begin
                    if (hs) begin
                        flit_cnt <= flit_cnt + 3'd1;
                        if (close) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flit_router_port.sv
// Scoreboard bench for flit_router_port: directed packets push expected flits, a negedge monitor checks handshakes.
module tb_flit_router_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_flit;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_flit;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       pkt_active;
    logic [7:0] drop_count;

    typedef struct {
        logic [7:0] flit;
        logic [1:0] chan;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    flit_router_port #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_active (pkt_active),
        .drop_count (drop_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; tasks start and end at that point.
    task automatic applyStimulus(input logic [7:0] f, input int chan);
        exp_t e;
        logic acc;
        bit   done;
        if (chan >= 0) begin
            e.flit = f;
            e.chan = chan[1:0];
            exp_q.push_back(e);
        end
        in_flit  = f;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_flit  = 8'h00;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp_q.size() == 0 && !pkt_active) done = 1'b1;
            else cycles(1);
        end
        cycles(3);
        checkOutput({name, "_drained"}, {31'd0, done}, 32'd1);
        checkOutput({name, "_pkt_active"}, {31'd0, pkt_active}, 32'd0);
    endtask

    // Monitor: every handshake seen at the next rising edge must match the oldest expected flit.
    always @(negedge clk) begin
        if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL unexpected_flit: got %0h on %b, required none", out_flit, out_valid);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_flit", {24'd0, out_flit}, {24'd0, mon_e.flit});
                checkOutput("out_valid", {28'd0, out_valid}, 32'd1 << mon_e.chan);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_flit   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        #12;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {28'd0, out_valid}, 32'd0);
        checkOutput("rst_out_flit", {24'd0, out_flit}, 32'd0);
        checkOutput("rst_pkt_active", {31'd0, pkt_active}, 32'd0);
        checkOutput("rst_drop_count", {24'd0, drop_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // Basic six-flit packet to channel 2
        out_ready = 4'hF;
        applyStimulus(8'hBE, 2);
        applyStimulus(8'h11, 2);
        applyStimulus(8'h22, 2);
        applyStimulus(8'h33, 2);
        applyStimulus(8'h44, 2);
        applyStimulus(8'hFF, 2);
        waitDrain("basic");
        checkOutput("basic_drop_count", {24'd0, drop_count}, 32'd0);

        // Short packet to channel 1
        applyStimulus(8'hBD, 1);
        applyStimulus(8'h55, 1);
        applyStimulus(8'hFF, 1);
        waitDrain("short");

        // Garbage flits are dropped before a channel 0 packet
        applyStimulus(8'h00, -1);
        applyStimulus(8'h7F, -1);
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hFF, 0);
        waitDrain("garbage");
        checkOutput("garbage_drop_count", {24'd0, drop_count}, 32'd2);

        // Forced close on the sixth flit; the following 8'hBC is a fresh header
        applyStimulus(8'hBF, 3);
        applyStimulus(8'h01, 3);
        applyStimulus(8'h02, 3);
        applyStimulus(8'h03, 3);
        applyStimulus(8'h04, 3);
        applyStimulus(8'h05, 3);
        applyStimulus(8'hBC, 0);
        applyStimulus(8'hFF, 0);
        waitDrain("forced");
        checkOutput("forced_drop_count", {24'd0, drop_count}, 32'd2);

        // Backpressure fills the FIFO; only the selected channel's ready drains it
        out_ready = 4'h0;
        applyStimulus(8'hBF, 3);
        applyStimulus(8'h01, 3);
        applyStimulus(8'h02, 3);
        applyStimulus(8'h03, 3);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        in_flit  = 8'h04;
        in_valid = 1'b1;
        cycles(2);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_out_flit", {24'd0, out_flit}, 32'hBF);
        checkOutput("bp_out_valid", {28'd0, out_valid}, 32'h8);
        checkOutput("bp_pkt_active", {31'd0, pkt_active}, 32'd1);
        out_ready = 4'b0001;
        cycles(2);
        checkOutput("wrong_ready_out_flit", {24'd0, out_flit}, 32'hBF);
        checkOutput("wrong_ready_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 4'b1000;
        applyStimulus(8'h04, 3);
        applyStimulus(8'hFF, 3);
        waitDrain("backpressure");

        // Asynchronous reset in the middle of a packet discards it
        out_ready = 4'h0;
        applyStimulus(8'hBE, -1);
        applyStimulus(8'h11, -1);
        applyStimulus(8'h22, -1);
        cycles(1);
        checkOutput("pre_rst_pkt_active", {31'd0, pkt_active}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_pkt_active", {31'd0, pkt_active}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_out_flit", {24'd0, out_flit}, 32'd0);
        checkOutput("mid_rst_drop_count", {24'd0, drop_count}, 32'd0);
        cycles(2);
        rst_n     = 1'b1;
        out_ready = 4'hF;
        cycles(2);
        checkOutput("post_rst_out_valid", {28'd0, out_valid}, 32'd0);
        applyStimulus(8'hBD, 1);
        applyStimulus(8'h55, 1);
        applyStimulus(8'hFF, 1);
        waitDrain("post_reset");

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flit_router_port.md
Name: flit_router_port

Overview:
- Router input port that sits directly downstream of the network interface packetizer.
- Accepts the NI's 8-bit flit stream and buffers it in a small FIFO.
- Decodes the header flit {6'b101111, dest[1:0]} and forwards the whole packet, wormhole style, to one of four output channels selected by dest.
- The output channel stays locked until the trailer flit has been forwarded.

Parameters:
- DEPTH, 4, FIFO depth in flits; power of two, 2..16.
- HDR_TAG, 6'b101111, required value of header bits [7:2].
- TRAILER, 8'hFF, trailer flit value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_flit  in  8  flit from NI.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  port can accept a flit; equals !full.
- out_flit  out  8  flit bus shared by all four output channels.
- out_valid  out  4  one-hot; bit d is set when out_flit is valid for channel d.
- out_ready  in  4  per-channel downstream ready.
- pkt_active  out  1  high while a packet is locked to a channel (state FWD).
- drop_count  out  8  saturating count of flits discarded because they were not a valid header in IDLE.

Behaviour:
- Reset (async assert, sync-released usage):
  - FIFO emptied, pointers 0.
  - state=IDLE, dest=0, flit_cnt=0, drop_count=0.
  - Outputs: in_ready=1, out_valid=0, out_flit=0, pkt_active=0.
- Reset mid-packet discards the buffered and partial packet. No trailer is generated.
- Push: in_valid && in_ready writes in_flit at wr_ptr.
  - in_ready depends only on full. No push is accepted while full, even if a pop occurs in the same cycle.
- Pop: occurs on a downstream handshake, or on a drop in IDLE. Simultaneous push and pop when not full and not empty leaves the occupancy unchanged.
- FIFO: pointers carry an extra wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- out_flit = FIFO head when state=FWD and not empty; otherwise 0.
- out_valid[dest] = (state==FWD) && !empty; the other bits are 0.
- Flit and valid are held stable while out_ready[dest]=0.
- out_ready bits of unselected channels are ignored.
- State machine, IDLE:
  - If !empty and head[7:2]==HDR_TAG: latch dest=head[1:0], flit_cnt=0, go to FWD. No pop.
  - If !empty and the header is invalid: pop, drop_count+1 (saturates at 255), stay in IDLE.
  - If empty: stay in IDLE.
- State machine, FWD: on each handshake (out_valid[dest] && out_ready[dest]):
  - Pop and increment flit_cnt.
  - The packet closes (go to IDLE) when flit_cnt>=1 and the popped flit==TRAILER, or when flit_cnt==5. The flit_cnt==5 case is the 6th flit: header + 4 data + trailer maximum.
  - The closing flit is forwarded normally.
- A data flit equal to TRAILER terminates the packet. This is the accepted protocol limitation, consistent with the NI's zero-byte truncation.
- Latency:
  - A header written into an empty FIFO at edge t shows on out_valid after edge t+2 (IDLE decode cycle).
  - Subsequent flits into an empty FIFO are visible after edge t+1.
  - Sustained throughput is 1 flit/cycle during FWD.
- Back-to-back packets: after the closing flit, IDLE needs one cycle to decode the next header. This is a one-cycle bubble per packet.

Optional Feature:
- Macro: STRIP_HEADER_EN.
- When defined:
  - On entering FWD, the header flit is popped in the IDLE decode cycle instead of being forwarded.
  - flit_cnt starts at 1.
  - Downstream sees only data and trailer flits.
  - Maximum forwarded length is 5 flits.
- When undefined: the header is forwarded as the first flit on the selected channel (behaviour above).

Test Plan:
- Basic packet: push 8'hBE (dest 2), 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF with out_ready=4'hF → exactly these 6 flits appear on out_flit with out_valid=4'b0100; pkt_active falls after 8'hFF; drop_count=0.
- Short packet: 8'hBD, 8'h55, 8'hFF → 3 flits on channel 1 (out_valid=4'b0010), return to IDLE.
- Garbage before header: push 8'h00, 8'h7F, then packet 8'hBC, 8'hAA, 8'hFF → drop_count=2; packet forwarded on channel 0.
- Backpressure/full: DEPTH=4, out_ready=0, push 6 flits → in_ready=0 after 4 accepted; out_flit holds 8'hBF stable; raising out_ready[3] drains all flits in order; out_ready[0] alone has no effect.
- Forced close: 8'hBF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, then 8'hBC, 8'hFF → first packet closes after 8'h05; 8'hBC is decoded as a new header for channel 0.
- Reset mid-packet: assert rst_n=0 after 3 flits of a 6-flit packet → FIFO empty, out_valid=0, pkt_active=0, in_ready=1 immediately (asynchronous); the next valid packet routes correctly.
